// File: rtl/acslip_slip_ctrl_if.sv
// -----------------------------------------------------------------------------
// acslip_slip_ctrl_if
// Correction handshake between the slip controller and the I2S RX sample FIFO.
//   drop_req_o : controller -> FIFO, discard one received sample
//   ins_req_o  : controller -> FIFO, duplicate one received sample
//   fifo_ack_i : FIFO -> controller, one-cycle acknowledge of the pending request
// Modports: master = controller side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface acslip_slip_ctrl_if;
  logic drop_req_o;
  logic ins_req_o;
  logic fifo_ack_i;

  modport master (output drop_req_o, output ins_req_o, input fifo_ack_i);
  modport slave  (input drop_req_o, input ins_req_o, output fifo_ack_i);
endinterface

// File: rtl/acslip_slip_ctrl.sv
// -----------------------------------------------------------------------------
// acslip_slip_ctrl
// Sequencing controller for the audio clock-slip accumulator. Watches the signed
// slip count, issues one-sample drop/insert corrections to the RX FIFO over a
// req/ack handshake, applies a hold-off after each correction and raises a
// sticky interrupt on an unrecoverable slip.
//
// Ports:
//   wbs_clk_i       system clock
//   acslip_rst      asynchronous active-high reset
//   ctrl_en_i       enable; low forces IDLE and clears the correction accumulator
//   slip_cnt_i      raw signed slip count
//   slip_thresh_i   correction threshold magnitude (0 behaves as 1)
//   slip_max_i      error threshold magnitude (0 disables the error check)
//   holdoff_i       hold-off length in units of 16 clocks
//   irq_clr_i       pulse, clears the sticky error (and leaves ERROR)
//   fifo_if         correction handshake (master side)
//   slip_err_irq_o  sticky error interrupt
//   eff_slip_o      slip_cnt_i - corr_acc (wrapping)
//   state_o         FSM state encoding
//
// Optional build macro ACSLIP_SLIP_CTRL_STATS_EN adds stats_clr_i and the
// saturating counters drop_cnt_o, ins_cnt_o, err_cnt_o.
//
// state    | meaning
// IDLE     | disabled
// SETTLE   | waiting SETTLE_CYC clocks after enable
// MONITOR  | comparing eff_slip against thresholds
// REQ_DROP | drop request outstanding
// REQ_INS  | insert request outstanding
// HOLDOFF  | post-correction hold-off
// ERROR    | unrecoverable slip, waiting for irq_clr_i
// -----------------------------------------------------------------------------
module acslip_slip_ctrl #(
  parameter int SLIP_W     = 32,
  parameter int THRESH_W   = 8,
  parameter int SETTLE_CYC = 1024
) (
  input  logic                wbs_clk_i,
  input  logic                acslip_rst,
  input  logic                ctrl_en_i,
  input  logic [SLIP_W-1:0]   slip_cnt_i,
  input  logic [THRESH_W-1:0] slip_thresh_i,
  input  logic [THRESH_W-1:0] slip_max_i,
  input  logic [THRESH_W-1:0] holdoff_i,
  input  logic                irq_clr_i,
  acslip_slip_ctrl_if.master  fifo_if,
  output logic                slip_err_irq_o,
  output logic [SLIP_W-1:0]   eff_slip_o,
  output logic [2:0]          state_o
`ifdef ACSLIP_SLIP_CTRL_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [15:0]         drop_cnt_o,
  output logic [15:0]         ins_cnt_o,
  output logic [7:0]          err_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    MONITOR  = 3'd2,
    REQ_DROP = 3'd3,
    REQ_INS  = 3'd4,
    HOLDOFF  = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int HOLD_W = THRESH_W + 4;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [SLIP_W-1:0]   corr_q, corr_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                irq_q, irq_d;
  logic                drop_req_q, ins_req_q;

  logic [SLIP_W-1:0]   eff, mag, thr_ext, neg_thr, max_ext;
  logic [THRESH_W-1:0] thr;
  logic                err_hit, drop_hit, ins_hit;

  assign eff     = slip_cnt_i - corr_q;
  // Negating -2^(SLIP_W-1) yields 2^(SLIP_W-1) as unsigned, the largest magnitude.
  assign mag     = eff[SLIP_W-1] ? (~eff + 1'b1) : eff;
  assign thr     = (slip_thresh_i == '0) ? THRESH_W'(1) : slip_thresh_i;
  assign thr_ext = {{(SLIP_W-THRESH_W){1'b0}}, thr};
  assign neg_thr = ~thr_ext + 1'b1;
  assign max_ext = {{(SLIP_W-THRESH_W){1'b0}}, slip_max_i};

  assign err_hit  = (slip_max_i != '0) && (mag >= max_ext);
  assign drop_hit = $signed(eff) >= $signed(thr_ext);
  assign ins_hit  = $signed(eff) <= $signed(neg_thr);

  always_comb begin
    state_d    = state_q;
    corr_d     = corr_q;
    set_cnt_d  = set_cnt_q;
    hold_cnt_d = hold_cnt_q;
    irq_d      = irq_q;
    if (irq_clr_i) irq_d = 1'b0;

    if (!ctrl_en_i) begin
      state_d = IDLE;
      corr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SETTLE;
          set_cnt_d = SET_LOAD;
        end
        SETTLE: begin
          if (set_cnt_q == '0) begin
            state_d = MONITOR;
            corr_d  = '0;
          end else begin
            set_cnt_d = set_cnt_q - 1'b1;
          end
        end
        MONITOR: begin
          if (err_hit)       state_d = ERROR;
          else if (drop_hit) state_d = REQ_DROP;
          else if (ins_hit)  state_d = REQ_INS;
        end
        REQ_DROP: begin
          if (fifo_if.fifo_ack_i) begin
            state_d    = HOLDOFF;
            corr_d     = corr_q + 1'b1;
            hold_cnt_d = {holdoff_i, 4'h0};
          end
        end
        REQ_INS: begin
          if (fifo_if.fifo_ack_i) begin
            state_d    = HOLDOFF;
            corr_d     = corr_q - 1'b1;
            hold_cnt_d = {holdoff_i, 4'h0};
          end
        end
        HOLDOFF: begin
          // Exit at 1 so a load of N*16 gives N*16 cycles; a load of 0 gives one.
          if (hold_cnt_q <= HOLD_W'(1)) state_d = MONITOR;
          else                          hold_cnt_d = hold_cnt_q - 1'b1;
        end
        ERROR: begin
          if (irq_clr_i) begin
            state_d   = SETTLE;
            corr_d    = '0;
            set_cnt_d = SET_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Entry wins over a simultaneous clear so the event is never lost.
    if (state_d == ERROR && state_q != ERROR) irq_d = 1'b1;
  end

  always_ff @(posedge wbs_clk_i or posedge acslip_rst) begin
    if (acslip_rst) begin
      state_q    <= IDLE;
      corr_q     <= '0;
      set_cnt_q  <= '0;
      hold_cnt_q <= '0;
      irq_q      <= 1'b0;
      drop_req_q <= 1'b0;
      ins_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      corr_q     <= corr_d;
      set_cnt_q  <= set_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      irq_q      <= irq_d;
      drop_req_q <= (state_d == REQ_DROP);
      ins_req_q  <= (state_d == REQ_INS);
    end
  end

  assign fifo_if.drop_req_o = drop_req_q;
  assign fifo_if.ins_req_o  = ins_req_q;
  assign slip_err_irq_o     = irq_q;
  assign eff_slip_o         = eff;
  assign state_o            = state_q;

`ifdef ACSLIP_SLIP_CTRL_STATS_EN
  logic [15:0] drop_cnt_q, ins_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge wbs_clk_i or posedge acslip_rst) begin
    if (acslip_rst) begin
      drop_cnt_q <= '0;
      ins_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else if (stats_clr_i) begin
      drop_cnt_q <= '0;
      ins_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == REQ_DROP && state_d == HOLDOFF && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 1'b1;
      if (state_q == REQ_INS && state_d == HOLDOFF && ins_cnt_q != '1)
        ins_cnt_q <= ins_cnt_q + 1'b1;
      if (state_d == ERROR && state_q != ERROR && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign ins_cnt_o  = ins_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_acslip_slip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acslip_slip_ctrl
// Self-checking bench for acslip_slip_ctrl (SETTLE_CYC = 4). Expected values
// are queued when stimulus is applied and compared when the DUT responds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acslip_slip_ctrl;
  localparam int SLIP_W     = 32;
  localparam int THRESH_W   = 8;
  localparam int SETTLE_CYC = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_MON = 3'd2,
                         S_DROP = 3'd3, S_INS = 3'd4, S_HOLD = 3'd5, S_ERR = 3'd6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                irq_clr = 1'b0;
  logic [SLIP_W-1:0]   slip = '0;
  logic [THRESH_W-1:0] thresh = '0, smax = '0, hold = '0;
  logic                irq;
  logic [SLIP_W-1:0]   eff;
  logic [2:0]          st;
`ifdef ACSLIP_SLIP_CTRL_STATS_EN
  logic                stats_clr = 1'b0;
  logic [15:0]         drop_cnt, ins_cnt;
  logic [7:0]          err_cnt;
`endif

  acslip_slip_ctrl_if fif ();

  acslip_slip_ctrl #(
    .SLIP_W(SLIP_W), .THRESH_W(THRESH_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .wbs_clk_i      (clk),
    .acslip_rst     (rst),
    .ctrl_en_i      (en),
    .slip_cnt_i     (slip),
    .slip_thresh_i  (thresh),
    .slip_max_i     (smax),
    .holdoff_i      (hold),
    .irq_clr_i      (irq_clr),
    .fifo_if        (fif.master),
    .slip_err_irq_o (irq),
    .eff_slip_o     (eff),
    .state_o        (st)
`ifdef ACSLIP_SLIP_CTRL_STATS_EN
    ,
    .stats_clr_i    (stats_clr),
    .drop_cnt_o     (drop_cnt),
    .ins_cnt_o      (ins_cnt),
    .err_cnt_o      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    chk(tag, obs, exp);
  endtask

  task automatic exp_now(input string tag, input logic [31:0] obs, input logic [31:0] v);
    sb_push(v);
    sb_check(tag, obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, output int n);
    n = 0;
    while (st !== s && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_pulse();
    fif.fifo_ack_i = 1'b1;
    tick();
    fif.fifo_ack_i = 1'b0;
  endtask

  initial begin
    int n, reqs;
    fif.fifo_ack_i = 1'b0;

    // reset values
    slip = 32'd5;
    #12;
    exp_now("rst_state", st, S_IDLE);
    exp_now("rst_drop", fif.drop_req_o, 0);
    exp_now("rst_ins", fif.ins_req_o, 0);
    exp_now("rst_irq", irq, 0);
    exp_now("rst_eff", eff, 32'd5);
    tick();
    rst = 1'b0;

    // settle and drop
    thresh = 8'd2; smax = 8'd100; hold = 8'd1; slip = 32'd2;
    en = 1'b1;
    sb_push(6);
    wait_state(S_DROP, 50, n);
    sb_check("drop_latency", n);
    exp_now("drop_req_hi", fif.drop_req_o, 1);
    exp_now("drop_ins_lo", fif.ins_req_o, 0);
    repeat (3) tick();
    exp_now("drop_req_held", fif.drop_req_o, 1);
    ack_pulse();
    exp_now("drop_req_fall", fif.drop_req_o, 0);
    exp_now("drop_eff", eff, 32'd1);
    exp_now("drop_hold_state", st, S_HOLD);
    sb_push(16);
    n = 0;
    while (st === S_HOLD && n < 100) begin n++; tick(); end
    sb_check("holdoff_len", n);
    exp_now("after_hold_state", st, S_MON);

    // insert path
    en = 1'b0;
    tick();
    exp_now("dis_state", st, S_IDLE);
    slip = 32'hFFFF_FFFD; thresh = 8'd3;
    en = 1'b1;
    sb_push(6);
    wait_state(S_INS, 50, n);
    sb_check("ins_latency", n);
    exp_now("ins_req_hi", fif.ins_req_o, 1);
    exp_now("ins_drop_lo", fif.drop_req_o, 0);
    ack_pulse();
    exp_now("ins_eff", eff, 32'hFFFF_FFFE);
    exp_now("ins_hold_state", st, S_HOLD);
    thresh = 8'd1;   // eff -2 would now trigger, but not during hold-off
    sb_push(16); sb_push(0);
    n = 0; reqs = 0;
    while (st === S_HOLD && n < 100) begin
      n++;
      if (fif.ins_req_o || fif.drop_req_o) reqs++;
      tick();
    end
    sb_check("ins_holdoff_len", n);
    sb_check("ins_hold_no_req", reqs);
    exp_now("ins_after_hold", st, S_MON);
    tick();
    exp_now("ins_retrigger", fif.ins_req_o, 1);
    en = 1'b0;
    tick();

    // error and clear
    slip = '0; thresh = 8'd20; smax = 8'd10; hold = 8'd0;
    en = 1'b1;
    sb_push(5);
    wait_state(S_MON, 50, n);
    sb_check("err_settle_lat", n);
    slip = 32'd5;
    tick();
    exp_now("err_below_max", st, S_MON);
    slip = 32'd10;
    tick();
    exp_now("err_state", st, S_ERR);
    exp_now("err_irq", irq, 1);
    reqs = 0;
    repeat (3) begin
      if (fif.ins_req_o || fif.drop_req_o) reqs++;
      tick();
    end
    exp_now("err_no_req", reqs, 0);
    exp_now("err_stays", st, S_ERR);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    exp_now("clr_state", st, S_SETTLE);
    exp_now("clr_irq", irq, 0);
    exp_now("clr_eff", eff, 32'd10);
    sb_push(5);
    wait_state(S_ERR, 50, n);
    sb_check("reerr_lat", n);
    en = 1'b0;
    tick();
    exp_now("dis_err_state", st, S_IDLE);
    exp_now("dis_irq_kept", irq, 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    exp_now("idle_irq_clr", irq, 0);

    // disable mid-request
    slip = 32'd2; thresh = 8'd2; smax = 8'd0;
    en = 1'b1;
    sb_push(6);
    wait_state(S_DROP, 50, n);
    sb_check("dis_drop_lat", n);
    en = 1'b0;
    tick();
    exp_now("dis_drop_lo", fif.drop_req_o, 0);
    exp_now("dis_drop_state", st, S_IDLE);
    ack_pulse();
    exp_now("late_ack_eff", eff, 32'd2);

    // boundary values
    thresh = 8'd0; slip = 32'd1;
    en = 1'b1;
    sb_push(6);
    wait_state(S_DROP, 50, n);
    sb_check("thr0_drop_lat", n);
    exp_now("thr0_drop_hi", fif.drop_req_o, 1);
    ack_pulse();
    exp_now("thr0_eff", eff, 32'd0);
    en = 1'b0;
    tick();
    slip = 32'h8000_0000; smax = 8'd255;
    en = 1'b1;
    sb_push(6);
    wait_state(S_ERR, 50, n);
    sb_check("minneg_err_lat", n);
    exp_now("minneg_irq", irq, 1);
    exp_now("minneg_no_ins", fif.ins_req_o, 0);
    en = 1'b0; irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;

`ifdef ACSLIP_SLIP_CTRL_STATS_EN
    exp_now("stat_drop", drop_cnt, 2);
    exp_now("stat_ins", ins_cnt, 1);
    exp_now("stat_err", err_cnt, 3);
`endif

    // asynchronous reset mid-REQ_INS
    slip = 32'hFFFF_FFFD; thresh = 8'd3; smax = 8'd0;
    en = 1'b1;
    sb_push(6);
    wait_state(S_INS, 50, n);
    sb_check("arst_ins_lat", n);
    exp_now("arst_ins_hi", fif.ins_req_o, 1);
    #2;
    rst = 1'b1;
    #1;
    exp_now("arst_ins", fif.ins_req_o, 0);
    exp_now("arst_drop", fif.drop_req_o, 0);
    exp_now("arst_state", st, S_IDLE);
    exp_now("arst_irq", irq, 0);
    exp_now("arst_eff", eff, 32'hFFFF_FFFD);
    rst = 1'b0;
    fif.fifo_ack_i = 1'b1;
    tick();
    fif.fifo_ack_i = 1'b0;
    exp_now("post_rst_state", st, S_SETTLE);
    exp_now("post_rst_ack_ign", eff, 32'hFFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/acslip_slip_ctrl.md
Name: acslip_slip_ctrl

Overview:
- Sequencing controller for the audio clock-slip (ACSLIP) accumulator.
- Monitors the signed slip count, which rises once per I2S-derived 16 kHz tick and falls once per reference 16 kHz tick.
- Sequences one-sample drop/insert corrections toward the I2S RX sample FIFO over a req/ack handshake, then applies a hold-off.
- Flags an unrecoverable slip to the Wishbone register block via a sticky interrupt; sits between the slip accumulator and the RX FIFO write path.

Parameters:
- SLIP_W, 32, width of the slip input and the internal correction accumulator (two's complement).
- THRESH_W, 8, width of the threshold and hold-off configuration fields.
- SETTLE_CYC, 1024, wbs_clk_i cycles to wait after enable before monitoring starts.

Ports:
- wbs_clk_i  in  1  system clock
- acslip_rst  in  1  reset acslip_rst, asynchronous, active-high; clock wbs_clk_i
- ctrl_en_i  in  1  controller enable; low forces IDLE
- slip_cnt_i  in  SLIP_W  raw signed slip count, synchronous to wbs_clk_i
- slip_thresh_i  in  THRESH_W  correction threshold magnitude; 0 is treated as 1
- slip_max_i  in  THRESH_W  error threshold magnitude
- holdoff_i  in  THRESH_W  hold-off length in units of 16 wbs_clk_i cycles
- irq_clr_i  in  1  one-cycle pulse; clears sticky error
- drop_req_o  out  1  request to discard one received sample
- ins_req_o  out  1  request to duplicate one received sample
- fifo_ack_i  in  1  one-cycle acknowledge from the FIFO for the pending request
- slip_err_irq_o  out  1  sticky error interrupt
- eff_slip_o  out  SLIP_W  effective slip = slip_cnt_i − corr_acc
- state_o  out  3  current FSM state encoding

Behaviour:
- Reset: FSM = IDLE; corr_acc = 0; all counters = 0; drop_req_o = 0; ins_req_o = 0; slip_err_irq_o = 0. eff_slip_o is therefore slip_cnt_i.
- eff_slip is computed combinationally from slip_cnt_i and the registered corr_acc.
- FSM states and encodings:
  - IDLE (0)
  - SETTLE (1)
  - MONITOR (2)
  - REQ_DROP (3)
  - REQ_INS (4)
  - HOLDOFF (5)
  - ERROR (6)
- IDLE → SETTLE when ctrl_en_i = 1. The settle counter loads SETTLE_CYC−1.
- SETTLE → MONITOR when the settle counter reaches 0. corr_acc is cleared on this transition.
- MONITOR, evaluated each cycle in priority order:
  1. If |eff_slip| ≥ slip_max_i and slip_max_i ≠ 0 → ERROR.
  2. Else if eff_slip ≥ +thr → REQ_DROP.
  3. Else if eff_slip ≤ −thr → REQ_INS.
  - thr = max(slip_thresh_i, 1).
- REQ_DROP / REQ_INS:
  - The matching req output is registered high from the first cycle in the state and held until fifo_ack_i is sampled high.
  - On ack: the req output drops on the next edge; corr_acc += 1 (drop) or −= 1 (insert); → HOLDOFF.
  - The hold-off counter loads {holdoff_i, 4'h0}.
  - An ack seen outside a REQ state is ignored.
- HOLDOFF → MONITOR when the counter reaches 0. When holdoff_i = 0, HOLDOFF lasts exactly 1 cycle.
- ERROR:
  - slip_err_irq_o is set on entry.
  - No requests are issued while in ERROR.
  - Exit to SETTLE requires irq_clr_i; this also clears slip_err_irq_o and corr_acc.
  - irq_clr_i in any other state clears only slip_err_irq_o.
- ctrl_en_i = 0 in any state → IDLE on the next edge, requests deassert immediately (registered), and corr_acc is cleared. slip_err_irq_o is retained until irq_clr_i.
- Mid-operation reset: all state returns to reset values asynchronously. An outstanding request is abandoned, and a later fifo_ack_i is ignored.
- Arithmetic:
  - eff_slip is SLIP_W-bit two's-complement wrap subtraction; no saturation.
  - Magnitude compare uses zero-extended thresholds.
  - |−2^(SLIP_W−1)| is treated as maximum magnitude, and so triggers ERROR.
- Latency: a threshold crossing in MONITOR raises the request 1 cycle later (registered).

Optional Feature:
- Macro: ACSLIP_SLIP_CTRL_STATS_EN.
- When defined, adds outputs:
  - drop_cnt_o [15:0], incremented per acknowledged drop.
  - ins_cnt_o [15:0], incremented per acknowledged insert.
  - err_cnt_o [7:0], incremented per ERROR entry.
- All three counters saturate at all-ones and clear on acslip_rst or a stats_clr_i pulse (extra input).
- When undefined, these ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Settle and drop: ctrl_en_i = 1, SETTLE_CYC = 4, thresh = 2, slip_cnt_i = 2 → drop_req_o rises 6 cycles after enable. Ack with a 3-cycle delay → req falls; eff_slip_o = 1; HOLDOFF lasts 16 cycles for holdoff_i = 1.
- Insert path: slip_cnt_i = −3, thresh = 3 → ins_req_o high; after ack, corr_acc = −1 and eff_slip_o = −2; no new request during HOLDOFF.
- Error and clear: slip_max_i = 10, slip_cnt_i steps to 10 → ERROR (state_o = 6) with slip_err_irq_o = 1 and no requests. irq_clr_i → SETTLE; irq = 0; eff_slip_o = 10.
- Disable mid-request: drop_req_o high, ctrl_en_i → 0 → drop_req_o = 0 next edge, state_o = 0; a late fifo_ack_i causes no corr_acc change.
- Boundary values: thresh = 0 with slip_cnt_i = 1 → drop issued (treated as 1). slip_cnt_i = 0x8000_0000 with slip_max_i = 255 → ERROR.
- Asynchronous reset: acslip_rst asserted mid-REQ_INS → all outputs 0 and state_o = 0 without any clock edge.
